// File: rtl/norm_pkg.sv
// Purpose: shared types and constants for the iterative normalizer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package norm_pkg;

  localparam int XLEN = 32;
  localparam int CW   = 6;

  // Mode codes match the ALU shifter type field so operand decode is shared.
  localparam logic [1:0] MODE_LEFT   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_SIGNED = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Binary-search step sizes, indexed by stage: [0]=16 ... [4]=1.
  localparam int NUM_STAGES = 5;
  localparam logic [4:0][4:0] STAGE_SHIFT = {5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

endpackage

// File: rtl/norm_step.sv
// Purpose: one binary-search normalization stage (test K bits, conditionally shift by K).
// Latency: combinational.
// Backpressure: none; driven by the norm_unit stage counter.
// Ports: value/mode/stage in -> shifted value and count increment out.
module norm_step
  import norm_pkg::*;
(
  input  logic [XLEN-1:0] value,
  input  logic [1:0]      mode,
  input  logic [2:0]      stage,
  output logic [XLEN-1:0] shifted,
  output logic [CW-1:0]   inc
);

  logic [4:0]             k;
  logic [XLEN-1:0]        top_bits;
  logic [XLEN-1:0]        low_bits;
  logic signed [XLEN-1:0] sval;
  logic [XLEN-1:0]        sign_run;

  always_comb begin
    k        = (stage < 3'(NUM_STAGES)) ? STAGE_SHIFT[stage] : 5'd0;
    // Isolate the top K bits / low K bits by shifting everything else out.
    top_bits = value >> (6'd32 - {1'b0, k});
    low_bits = value << (6'd32 - {1'b0, k});
    // Arithmetic shift leaves only copies of the top K+1 bits; they are all
    // equal exactly when the whole result is all-zeros or all-ones.
    sval     = value;
    sign_run = sval >>> (5'd31 - k);

    shifted  = value;
    inc      = '0;
    case (mode)
      MODE_LEFT: begin
        if (top_bits == '0) begin
          shifted = value << k;
          inc     = {1'b0, k};
        end
      end
      MODE_RIGHT: begin
        if (low_bits == '0) begin
          shifted = value >> k;
          inc     = {1'b0, k};
        end
      end
      MODE_SIGNED: begin
        if ((sign_run == '0) || (sign_run == '1)) begin
          shifted = value << k;
          inc     = {1'b0, k};
        end
      end
      default: begin
        shifted = value;
        inc     = '0;
      end
    endcase
  end

endmodule

// File: rtl/norm_unit.sv
// Purpose: iterative CLZ/CTZ/CLS normalizer, one binary-search stage per cycle.
// Latency: out_valid 5 cycles after acceptance; no overlap, 7-cycle throughput.
// Backpressure: results held stable while out_ready is low; in_ready low until drained.
// Ports: in_valid/in_ready/a/mode request side; out_valid/out_ready/r/count/zero result side.
module norm_unit
  import norm_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [1:0]      mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] r,
  output logic [CW-1:0]   count,
  output logic            zero
);

  state_t          state;
  logic [2:0]      stage;
  logic [XLEN-1:0] work;
  logic [1:0]      md;
  logic            zero_w;
  logic [CW-1:0]   cnt;

  logic [XLEN-1:0] step_val;
  logic [CW-1:0]   step_inc;
  logic [CW-1:0]   next_cnt;
  logic [CW-1:0]   fixed_cnt;

  norm_step u_step (
    .value   (work),
    .mode    (md),
    .stage   (stage),
    .shifted (step_val),
    .inc     (step_inc)
  );

  assign in_ready = (state == IDLE);

  // Search tops out at 31; a still-clear end bit after the last stage means
  // the operand was zero, which reports a full-width count of 32.
  always_comb begin
    next_cnt  = cnt + step_inc;
    fixed_cnt = next_cnt;
    if ((md == MODE_LEFT) && !step_val[XLEN-1])
      fixed_cnt = 6'd32;
    else if ((md == MODE_RIGHT) && !step_val[0])
      fixed_cnt = 6'd32;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stage     <= '0;
      work      <= '0;
      md        <= MODE_LEFT;
      zero_w    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      r         <= '0;
      count     <= '0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work   <= a;
            md     <= mode;
            zero_w <= (a == '0) && (mode != MODE_RSVD);
            cnt    <= '0;
            stage  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          work <= step_val;
          if (stage == 3'(NUM_STAGES - 1)) begin
            cnt       <= fixed_cnt;
            r         <= step_val;
            count     <= fixed_cnt;
            zero      <= zero_w;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt   <= next_cnt;
            stage <= stage + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_unit.sv
module tb_norm_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] r;
  logic [5:0]  count;
  logic        zero;

  int tests = 0;
  int fails = 0;

  norm_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .count     (count),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] r;
    logic [5:0]  cnt;
    logic        z;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge, then count edges until out_valid.
  task automatic run_op(input logic [1:0] m, input logic [31:0] av, input string tag,
                        output int lat);
    bit found;
    @(negedge clk);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a        = av;
    mode     = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 32'hA5A5A5A5;
    mode     = 2'b11;
    found = 1'b0;
    lat   = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat   = i;
        found = 1'b1;
        break;
      end
    end
    if (!found) lat = 99;
  endtask

  initial begin
    int lat;

    vecs[0]  = '{2'b00, 32'h00010000, 32'h80000000, 6'd15, 1'b0};
    vecs[1]  = '{2'b00, 32'h00000000, 32'h00000000, 6'd32, 1'b1};
    vecs[2]  = '{2'b01, 32'h00000000, 32'h00000000, 6'd32, 1'b1};
    vecs[3]  = '{2'b01, 32'h00000100, 32'h00000001, 6'd8,  1'b0};
    vecs[4]  = '{2'b01, 32'h80000000, 32'h00000001, 6'd31, 1'b0};
    vecs[5]  = '{2'b10, 32'hFFFF8000, 32'h80000000, 6'd16, 1'b0};
    vecs[6]  = '{2'b10, 32'h00000001, 32'h40000000, 6'd30, 1'b0};
    vecs[7]  = '{2'b10, 32'hFFFFFFFF, 32'h80000000, 6'd31, 1'b0};
    vecs[8]  = '{2'b11, 32'h00001234, 32'h00001234, 6'd0,  1'b0};
    vecs[9]  = '{2'b10, 32'h00000000, 32'h00000000, 6'd31, 1'b1};
    vecs[10] = '{2'b00, 32'h80000000, 32'h80000000, 6'd0,  1'b0};
    vecs[11] = '{2'b01, 32'h00000001, 32'h00000001, 6'd0,  1'b0};
    vecs[12] = '{2'b00, 32'h00000F00, 32'hF0000000, 6'd20, 1'b0};
    vecs[13] = '{2'b01, 32'h00000F00, 32'h0000000F, 6'd8,  1'b0};
    vecs[14] = '{2'b10, 32'h7FFFFFFF, 32'h7FFFFFFF, 6'd0,  1'b0};
    vecs[15] = '{2'b11, 32'h00000000, 32'h00000000, 6'd0,  1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    mode      = 2'b00;
    out_ready = 1'b1;
    #23;
    check("reset in_ready",  {31'd0, in_ready},  32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset r",         r,                  32'd0);
    check("reset count",     {26'd0, count},     32'd0);
    check("reset zero",      {31'd0, zero},      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors with out_ready held high.
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].mode, vecs[i].a, $sformatf("v%0d", i), lat);
      check($sformatf("v%0d latency", i), lat, 32'd5);
      check($sformatf("v%0d r", i), r, vecs[i].r);
      check($sformatf("v%0d count", i), {26'd0, count}, {26'd0, vecs[i].cnt});
      check($sformatf("v%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].z});
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid drop", i), {31'd0, out_valid}, 32'd0);
    end

    // Back-pressure: hold the result for 10 cycles, pulse a stray request.
    out_ready = 1'b0;
    run_op(2'b00, 32'h00F00000, "bp", lat);
    check("bp latency", lat, 32'd5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 4);
      a        = 32'hDEADBEEF;
      mode     = 2'b01;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp%0d r", i), r, 32'hF0000000);
      check($sformatf("bp%0d count", i), {26'd0, count}, 32'd8);
      check($sformatf("bp%0d zero", i), {31'd0, zero}, 32'd0);
      check($sformatf("bp%0d in_ready", i), {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release out_valid", {31'd0, out_valid}, 32'd0);
    check("bp release in_ready",  {31'd0, in_ready},  32'd1);
    run_op(2'b01, 32'h00000100, "bp next", lat);
    check("bp next latency", lat, 32'd5);
    check("bp next r", r, 32'h00000001);
    check("bp next count", {26'd0, count}, 32'd8);
    @(posedge clk);
    #1;

    // Reset during RUN stage 3: result discarded, unit idle at once.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'h12345678;
    mode     = 2'b00;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst in_ready",  {31'd0, in_ready},  32'd1);
    check("rst count",     {26'd0, count},     32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rst no stray result", {31'd0, out_valid}, 32'd0);
    run_op(2'b00, 32'h00000001, "post rst", lat);
    check("post rst latency", lat, 32'd5);
    check("post rst r", r, 32'h80000000);
    check("post rst count", {26'd0, count}, 32'd31);
    check("post rst zero", {31'd0, zero}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
